alu_int_arbiter: RTL and testbench
==================================

ALU_INT_ARBITER -- requirements
Module: alu_int_arbiter

Interface
REQ-001 Parameter: FAIR, default 1, meaning 1 = round-robin between requesters and 0 = fixed priority to requester 0.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 REQn_VALID  input  1  (n=0,1) requester n presents an operation.
REQ-005 REQn_READY  output  1  arbiter accepts requester n this cycle.
REQ-006 REQn_OP1, REQn_OP2  input  32  operands from requester n.
REQ-007 REQn_ALU_OP  input  5  operation code from requester n; legal codes are 0-7, 13 and 16.
REQ-008 RSPn_VALID  output  1  response for requester n is available.
REQ-009 RSPn_READY  input  1  requester n takes the response.
REQ-010 RSPn_RESULT  output  32  result; RSPn_ZERO, RSPn_SIGN, RSPn_SLTU  output  1 each  captured ALU flags; RSPn_ERR  output  1  illegal opcode.
REQ-011 ALU_OP1, ALU_OP2  output  32; ALU_OP_OUT  output  5  drive the shared integer ALU.
REQ-012 ALU_RESULT  input  32; ALU_ZERO, ALU_SIGN_BIT, ALU_SLTU_BIT  input  1  returned from the shared ALU; settle within one CLK period.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, EXEC and RESP, and SHALL hold exactly one transaction at a time.
REQ-014 In IDLE, the arbiter SHALL assert REQn_READY only for the granted requester; grant is combinational from REQn_VALID and LAST_GRANT.
REQ-015 With FAIR=1, the arbiter SHALL resolve simultaneous valids by granting the requester not named in LAST_GRANT; with FAIR=0, requester 0 always wins.
REQ-016 A single valid requester SHALL be granted regardless of LAST_GRANT.
REQ-017 On an accepted handshake (VALID & READY in IDLE), the arbiter SHALL latch OP1, OP2, ALU_OP and the owner id, update LAST_GRANT to the owner, and enter EXEC.
REQ-018 In EXEC, the arbiter SHALL drive ALU_OP1, ALU_OP2 and ALU_OP_OUT from the latched values.
REQ-019 At the end of the EXEC cycle, the arbiter SHALL capture ALU_RESULT and the three flags into the response register and enter RESP.
REQ-020 If the latched opcode is illegal, the arbiter SHALL capture RESULT=0, ZERO=1, SIGN=0, SLTU=0 and ERR=1 instead of the ALU outputs; legal opcodes give ERR=0.
REQ-021 In RESP, the arbiter SHALL assert RSPn_VALID for the owner only, hold the response stable until RSPn_READY, then return to IDLE on that edge.
REQ-022 Latency SHALL be: request accepted at edge N, RSP_VALID high from edge N+2; maximum throughput is one operation per 3 cycles.
REQ-023 REQn_READY SHALL be 0 in EXEC and RESP; requests arriving then SHALL wait, and VALID need not be held.
REQ-024 Outside EXEC, the arbiter SHALL drive the ALU with ALU_OP_OUT=16 and ALU_OP1=ALU_OP2=0.
REQ-025 RSPn_READY asserted without RSPn_VALID SHALL be ignored; the non-owner's RSP_VALID SHALL stay 0.

Reset
REQ-026 RESET low SHALL immediately force the following, asynchronously:
- state=IDLE
- LAST_GRANT=1 (requester 0 wins the first tie)
- all RSPn_VALID=0, RSPn_RESULT=0, flags=0, ERR=0
- REQn_READY=0 while reset is asserted
- ALU outputs at the idle values of REQ-024
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight transaction with no response.
REQ-028 After RESET deasserts, the arbiter SHALL accept requests from the first rising edge.

Verification
REQ-029 Single request: REQ0 ADD 5+7 (op 0) -> RSP0 RESULT=12, ZERO=0, ERR=0, RSP_VALID at N+2.
REQ-030 Tie with FAIR=1: both valid every cycle from reset -> grants 0,1,0,1; RSP1 SUB-free SLT(-1,1) gives RESULT=1, SIGN=0.
REQ-031 Tie with FAIR=0: both valid continuously -> requester 0 is granted every time and requester 1 starves.
REQ-032 Backpressure: hold RSP0_READY=0 for 5 cycles on XOR(0xFFFF0000, 0x0000FFFF) -> RESULT stays 0xFFFFFFFF, REQ1_READY=0 throughout, then IDLE one edge after READY.
REQ-033 Illegal op 9 from REQ1 -> RSP1 RESULT=0, ZERO=1, ERR=1, and ALU_OP_OUT is never 9.
REQ-034 RESET asserted mid-EXEC -> no RSP_VALID afterwards, LAST_GRANT=1, and the next tie grants requester 0.

Source files
------------

// File: rtl/alu_int_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_int_arbiter_if : one requester channel (request + response)       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface alu_int_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  alu_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_sign;
    logic        rsp_sltu;
    logic        rsp_err;

    modport master (
        output req_valid, op1, op2, alu_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_sign, rsp_sltu, rsp_err
    );

    modport slave (
        input  req_valid, op1, op2, alu_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_sign, rsp_sltu, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_int_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_int_arbiter : two requesters sharing one integer ALU, one op at a |
// | time (IDLE -> EXEC -> RESP).                      Rev 1.0              |
// +----------------------------------------------------------------------+
module alu_int_arbiter #(
    parameter int FAIR = 1
) (
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    alu_int_arbiter_if.slave  req0_if,
    alu_int_arbiter_if.slave  req1_if,
    output logic [31:0]       alu_op1_o,
    output logic [31:0]       alu_op2_o,
    output logic [4:0]        alu_op_out_o,
    input  wire logic [31:0]  alu_result_i,
    input  wire logic         alu_zero_i,
    input  wire logic         alu_sign_bit_i,
    input  wire logic         alu_sltu_bit_i
);

    localparam logic [4:0] ALU_OP_IDLE = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_grant_q;
    logic        owner_q;
    logic        illegal_q;
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp_result_q;
    logic        rsp_zero_q;
    logic        rsp_sign_q;
    logic        rsp_sltu_q;
    logic        rsp_err_q;
    logic [31:0] alu_op1_q;
    logic [31:0] alu_op2_q;
    logic [4:0]  alu_op_q;

    logic        w_grant_any;
    logic        w_grant_id;
    logic        w_accept;
    logic        w_sel_legal;
    logic        w_owner_rsp_ready;
    logic [31:0] w_sel_op1;
    logic [31:0] w_sel_op2;
    logic [4:0]  w_sel_op;

    function automatic logic op_legal(input logic [4:0] op);
        return (op <= 5'd7) || (op == 5'd13) || (op == 5'd16);
    endfunction

    // On a tie, FAIR hands the grant to whoever did not win last time.
    always_comb begin
        w_grant_any = req0_if.req_valid | req1_if.req_valid;
        if (req0_if.req_valid && req1_if.req_valid) begin
            w_grant_id = (FAIR != 0) ? ~last_grant_q : 1'b0;
        end else begin
            w_grant_id = req1_if.req_valid;
        end
    end

    assign w_accept          = (state_q == S_IDLE) && rst_ni && w_grant_any;
    assign req0_if.req_ready = w_accept && !w_grant_id;
    assign req1_if.req_ready = w_accept &&  w_grant_id;

    assign w_sel_op1         = w_grant_id ? req1_if.op1    : req0_if.op1;
    assign w_sel_op2         = w_grant_id ? req1_if.op2    : req0_if.op2;
    assign w_sel_op          = w_grant_id ? req1_if.alu_op : req0_if.alu_op;
    assign w_sel_legal       = op_legal(w_sel_op);
    assign w_owner_rsp_ready = owner_q ? req1_if.rsp_ready : req0_if.rsp_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            illegal_q    <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= 32'd0;
            rsp_zero_q   <= 1'b0;
            rsp_sign_q   <= 1'b0;
            rsp_sltu_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            alu_op1_q    <= 32'd0;
            alu_op2_q    <= 32'd0;
            alu_op_q     <= ALU_OP_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        owner_q      <= w_grant_id;
                        last_grant_q <= w_grant_id;
                        illegal_q    <= !w_sel_legal;
                        // Illegal codes never reach the ALU; it stays on the idle op.
                        if (w_sel_legal) begin
                            alu_op1_q <= w_sel_op1;
                            alu_op2_q <= w_sel_op2;
                            alu_op_q  <= w_sel_op;
                        end
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (illegal_q) begin
                        rsp_result_q <= 32'd0;
                        rsp_zero_q   <= 1'b1;
                        rsp_sign_q   <= 1'b0;
                        rsp_sltu_q   <= 1'b0;
                        rsp_err_q    <= 1'b1;
                    end else begin
                        rsp_result_q <= alu_result_i;
                        rsp_zero_q   <= alu_zero_i;
                        rsp_sign_q   <= alu_sign_bit_i;
                        rsp_sltu_q   <= alu_sltu_bit_i;
                        rsp_err_q    <= 1'b0;
                    end
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    alu_op1_q   <= 32'd0;
                    alu_op2_q   <= 32'd0;
                    alu_op_q    <= ALU_OP_IDLE;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (w_owner_rsp_ready) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_op1_o    = alu_op1_q;
    assign alu_op2_o    = alu_op2_q;
    assign alu_op_out_o = alu_op_q;

    assign req0_if.rsp_valid  = rsp_valid_q[0];
    assign req1_if.rsp_valid  = rsp_valid_q[1];
    assign req0_if.rsp_result = rsp_result_q;
    assign req1_if.rsp_result = rsp_result_q;
    assign req0_if.rsp_zero   = rsp_zero_q;
    assign req1_if.rsp_zero   = rsp_zero_q;
    assign req0_if.rsp_sign   = rsp_sign_q;
    assign req1_if.rsp_sign   = rsp_sign_q;
    assign req0_if.rsp_sltu   = rsp_sltu_q;
    assign req1_if.rsp_sltu   = rsp_sltu_q;
    assign req0_if.rsp_err    = rsp_err_q;
    assign req1_if.rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_int_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_int_arbiter : randomized + directed scoreboard bench           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_alu_int_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_int_arbiter_if rq0 ();
    alu_int_arbiter_if rq1 ();
    alu_int_arbiter_if fp0 ();
    alu_int_arbiter_if fp1 ();

    logic [31:0] alu_a, alu_b, alu_res, fp_a, fp_b, fp_res;
    logic [4:0]  alu_op, fp_op;
    logic        alu_z, alu_s, alu_u, fp_z, fp_s, fp_u;

    alu_int_arbiter #(.FAIR(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req0_if(rq0), .req1_if(rq1),
        .alu_op1_o(alu_a), .alu_op2_o(alu_b), .alu_op_out_o(alu_op),
        .alu_result_i(alu_res), .alu_zero_i(alu_z),
        .alu_sign_bit_i(alu_s), .alu_sltu_bit_i(alu_u)
    );

    alu_int_arbiter #(.FAIR(0)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n), .req0_if(fp0), .req1_if(fp1),
        .alu_op1_o(fp_a), .alu_op2_o(fp_b), .alu_op_out_o(fp_op),
        .alu_result_i(fp_res), .alu_zero_i(fp_z),
        .alu_sign_bit_i(fp_s), .alu_sltu_bit_i(fp_u)
    );

    // Stand-in shared ALU; the opcode meanings are this bench's own choice.
    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return {31'd0, $signed(a) < $signed(b)};
            5'd4:  return {31'd0, a < b};
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return a | b;
            5'd13: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_res = alu_fn(alu_op, alu_a, alu_b);
        alu_z   = (alu_res == 32'd0);
        alu_s   = alu_res[31];
        alu_u   = (alu_a < alu_b);
        fp_res  = alu_fn(fp_op, fp_a, fp_b);
        fp_z    = (fp_res == 32'd0);
        fp_s    = fp_res[31];
        fp_u    = (fp_a < fp_b);
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        int          owner;
        logic [35:0] pay;   // {result, zero, sign, sltu, err}
        int          pc;    // cycle in which the response must first appear
    } exp_t;
    exp_t sbq[$];

    int          m_last = 1;
    bit          m_busy = 0;
    int          m_owner, m_exec_cyc, m_rsp_cyc;
    logic [4:0]  m_op;
    logic [31:0] m_a, m_b;
    bit          m_legal;

    function automatic bit is_legal(input logic [4:0] op);
        return (op inside {[5'd0:5'd7], 5'd13, 5'd16});
    endfunction

    function automatic int pick(input bit v0, input bit v1, input int last_g);
        if (v0 && v1) return 1 - last_g;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic exp_t predict(input int own, input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input int pc);
        exp_t e;
        logic [31:0] r;
        e.owner = own;
        e.pc    = pc;
        if (!is_legal(op)) begin
            e.pay = {32'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        end else begin
            r     = alu_fn(op, a, b);
            e.pay = {r, r == 32'd0, r[31], a < b, 1'b0};
        end
        return e;
    endfunction

    // ---------------- stimulus state ----------------
    bit          s_v0, s_v1, s_r0, s_r1;
    logic [4:0]  s_o0, s_o1;
    logic [31:0] s_a0, s_b0, s_a1, s_b1;
    bit          mon_have = 0;
    exp_t        mon_cur;

    task automatic drive();
        rq0.req_valid = s_v0; rq0.alu_op = s_o0; rq0.op1 = s_a0; rq0.op2 = s_b0; rq0.rsp_ready = s_r0;
        rq1.req_valid = s_v1; rq1.alu_op = s_o1; rq1.op1 = s_a1; rq1.op2 = s_b1; rq1.rsp_ready = s_r1;
    endtask

    // Runs mid-cycle: checks grant/ALU drive, then advances the model past the next edge.
    task automatic model_check();
        int g;
        logic [68:0] alu_exp;
        g = m_busy ? -1 : pick(s_v0, s_v1, m_last);
        check("req0_ready", rq0.req_ready, g == 0);
        check("req1_ready", rq1.req_ready, g == 1);
        if (m_busy && cyc == m_exec_cyc && m_legal) alu_exp = {m_op, m_a, m_b};
        else                                         alu_exp = {5'd16, 32'd0, 32'd0};
        check("alu_drive", {alu_op, alu_a, alu_b}, alu_exp);
        if (m_busy) begin
            if (cyc >= m_rsp_cyc && ((m_owner == 0) ? s_r0 : s_r1)) m_busy = 0;
        end else if (g >= 0) begin
            m_owner    = g;
            m_last     = g;
            m_busy     = 1;
            m_exec_cyc = cyc + 1;
            m_rsp_cyc  = cyc + 2;
            m_op       = (g == 0) ? s_o0 : s_o1;
            m_a        = (g == 0) ? s_a0 : s_a1;
            m_b        = (g == 0) ? s_b0 : s_b1;
            m_legal    = is_legal(m_op);
            sbq.push_back(predict(g, m_op, m_a, m_b, m_rsp_cyc));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        #1 drive();
        @(negedge clk);
        model_check();
    endtask

    task automatic set_req(input int n, input bit v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin s_v0 = v; s_o0 = op; s_a0 = a; s_b0 = b; end
        else        begin s_v1 = v; s_o1 = op; s_a1 = a; s_b1 = b; end
    endtask

    task automatic idle_cycles(input int n);
        s_v0 = 0; s_v1 = 0; s_r0 = 1; s_r1 = 1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asserts reset mid-cycle with both requesters valid, then releases it.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        set_req(0, 1, 5'd0, 32'd3, 32'd4);
        set_req(1, 1, 5'd0, 32'd8, 32'd9);
        s_r0 = 1; s_r1 = 1;
        drive();
        #1;
        check("rst_ready", {rq0.req_ready, rq1.req_ready}, 2'b00);
        check("rst_rsp_valid", {rq0.rsp_valid, rq1.rsp_valid}, 2'b00);
        check("rst_rsp_regs", {rq0.rsp_result, rq0.rsp_zero, rq0.rsp_sign, rq0.rsp_sltu, rq0.rsp_err}, 36'd0);
        check("rst_alu_idle", {alu_op, alu_a, alu_b}, {5'd16, 64'd0});
        sbq.delete();
        mon_have = 0;
        m_busy   = 0;
        m_last   = 1;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 model_check();
    endtask

    // ---------------- response monitor ----------------
    int          mon_n;
    logic [35:0] mon_act;
    always @(negedge clk) begin
        if (rst_n) begin
            check("rsp_valid_exclusive", rq0.rsp_valid & rq1.rsp_valid, 1'b0);
            if (rq0.rsp_valid || rq1.rsp_valid) begin
                mon_n   = rq1.rsp_valid ? 1 : 0;
                mon_act = mon_n ? {rq1.rsp_result, rq1.rsp_zero, rq1.rsp_sign, rq1.rsp_sltu, rq1.rsp_err}
                                : {rq0.rsp_result, rq0.rsp_zero, rq0.rsp_sign, rq0.rsp_sltu, rq0.rsp_err};
                if (!mon_have) begin
                    if (sbq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got valid on rsp%0d expected none (cycle %0d)", mon_n, cyc);
                    end else begin
                        mon_cur  = sbq.pop_front();
                        mon_have = 1;
                        check("rsp_latency", cyc, mon_cur.pc);
                        check("rsp_owner", mon_n, mon_cur.owner);
                    end
                end
                if (mon_have) begin
                    check("rsp_payload", mon_act, mon_cur.pay);
                    if (mon_n ? rq1.rsp_ready : rq0.rsp_ready) mon_have = 0;
                end
            end
        end
    end

    // Fixed-priority instance: both always valid, requester 1 must starve.
    int fp_rsp0 = 0;
    initial begin
        fp0.req_valid = 1; fp0.alu_op = 5'd0; fp0.op1 = 32'd1; fp0.op2 = 32'd2; fp0.rsp_ready = 1;
        fp1.req_valid = 1; fp1.alu_op = 5'd0; fp1.op1 = 32'd5; fp1.op2 = 32'd6; fp1.rsp_ready = 1;
    end
    always @(negedge clk) begin
        if (rst_n) begin
            check("fp_req1_ready", fp1.req_ready, 1'b0);
            check("fp_rsp1_valid", fp1.rsp_valid, 1'b0);
            if (fp0.rsp_valid) begin
                fp_rsp0++;
                check("fp_rsp0_result", fp0.rsp_result, 32'd3);
            end
        end
    end

    // ---------------- main sequence ----------------
    logic [4:0] ops_tbl [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                 5'd13, 5'd16, 5'd9, 5'd20, 5'd31};
    int guard;

    initial begin
        s_v0 = 0; s_v1 = 0; s_r0 = 1; s_r1 = 1;
        s_o0 = 0; s_o1 = 0; s_a0 = 0; s_b0 = 0; s_a1 = 0; s_b1 = 0;
        drive();
        @(negedge clk);
        do_reset();
        idle_cycles(2);

        // single ADD 5+7 from requester 0
        set_req(0, 1, 5'd0, 32'd5, 32'd7); cycle();
        set_req(0, 0, 5'd0, 32'd0, 32'd0); idle_cycles(4);

        // ties: round robin, requester 1 does SLT(-1,1)
        set_req(0, 1, 5'd1, 32'd10, 32'd3);
        set_req(1, 1, 5'd3, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 14; i++) cycle();
        idle_cycles(4);

        // backpressure on XOR while requester 1 waits
        set_req(0, 1, 5'd5, 32'hFFFF_0000, 32'h0000_FFFF); s_r0 = 0; cycle();
        set_req(0, 0, 5'd0, 32'd0, 32'd0);
        set_req(1, 1, 5'd7, 32'h0F0F_0000, 32'h0000_00F0);
        for (int i = 0; i < 6; i++) cycle();
        s_r0 = 1;
        for (int i = 0; i < 4; i++) cycle();
        idle_cycles(4);

        // illegal op 9 from requester 1
        set_req(1, 1, 5'd9, 32'd123, 32'd456); cycle();
        set_req(1, 0, 5'd0, 32'd0, 32'd0); idle_cycles(4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_req(0, 1'($urandom_range(0, 1)), ops_tbl[$urandom_range(0, 12)], $urandom, $urandom);
            set_req(1, 1'($urandom_range(0, 1)), ops_tbl[$urandom_range(0, 12)], $urandom, $urandom);
            s_r0 = ($urandom_range(0, 9) < 7);
            s_r1 = ($urandom_range(0, 9) < 7);
            cycle();
        end
        idle_cycles(4);

        // reset while a tie-won transaction is in EXEC
        set_req(0, 1, 5'd0, 32'd1, 32'd1);
        set_req(1, 1, 5'd0, 32'd2, 32'd2);
        guard = 0;
        do begin
            cycle();
            guard++;
        end while (!(m_busy && cyc == m_exec_cyc) && guard < 10);
        check("exec_reached", guard < 10, 1'b1);
        do_reset();
        for (int i = 0; i < 6; i++) cycle();
        idle_cycles(6);

        check("scoreboard_drained", sbq.size(), 0);
        check("no_pending_rsp", mon_have, 1'b0);
        check("fp_req0_served", fp_rsp0 >= 3, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
